// File: rtl/ysyx_23060171_pcu.sv
// ysyx_23060171_pcu: program counter unit.
// Holds the PC. It offers the PC to fetch and then takes the next-PC decision
// from execute. The two handshakes alternate.
// Optional build macro YSYX_23060171_PCU_MISALIGN_EN enables target alignment
// checking. A misaligned target parks the unit in HALT with a sticky misalign flag.
module ysyx_23060171_pcu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        redirect,
  output logic        misalign
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Next-PC selection. Reserved select 2'b11 falls back to sequential.
  function automatic logic [31:0] calc_target(
    input logic [1:0]  src,
    input logic [31:0] pc_v,
    input logic [31:0] imm_v,
    input logic [31:0] rs1_v
  );
    logic [31:0] t;
    case (src)
      2'b01:   t = pc_v + imm_v;
      2'b10:   t = (rs1_v + imm_v) & ~32'd1;
      default: t = pc_v + 32'd4;
    endcase
    return t;
  endfunction

  // Only jump and branch-register selections count as a redirect.
  function automatic logic is_redirect(input logic [1:0] src);
    return (src == 2'b01) || (src == 2'b10);
  endfunction

  state_t      state_r;
  logic [31:0] pc_r;
  logic        redirect_r;
  logic        out_valid_r;
  logic        in_ready_r;
  logic [31:0] target_s;
  logic        fault_s;

  // Target computation and alignment fault detection.
  always_comb begin
    target_s = calc_target(PCSrc, pc_r, imm, rs1);
`ifdef YSYX_23060171_PCU_MISALIGN_EN
    if (target_s[1:0] != 2'b00) begin
      fault_s = 1'b1;
    end else begin
      fault_s = 1'b0;
    end
`else
    fault_s = 1'b0;
`endif
  end

`ifdef YSYX_23060171_PCU_MISALIGN_EN
  logic misalign_r;

  // Sticky misalign flag. It clears only on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else if (state_r == EXEC && in_valid && fault_s) begin
      misalign_r <= 1'b1;
    end
  end

  assign misalign = misalign_r;
`else
  assign misalign = 1'b0;
`endif

  // Control FSM. Handshake outputs are registered alongside the state.
  // Reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= FETCH;
      pc_r        <= RESET_PC;
      redirect_r  <= 1'b0;
      out_valid_r <= 1'b1;
      in_ready_r  <= 1'b0;
    end else begin
      redirect_r <= 1'b0;
      case (state_r)
        FETCH: begin
          if (out_ready) begin
            state_r     <= EXEC;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        EXEC: begin
          if (in_valid) begin
            if (fault_s) begin
              // Misaligned target: keep pc and park until reset.
              state_r     <= HALT;
              out_valid_r <= 1'b0;
              in_ready_r  <= 1'b0;
            end else begin
              pc_r        <= target_s;
              redirect_r  <= is_redirect(PCSrc);
              state_r     <= FETCH;
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
            end
          end
        end
        HALT: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b0;
        end
        default: begin
          // Unreachable encoding: recover into a clean fetch.
          state_r     <= FETCH;
          out_valid_r <= 1'b1;
          in_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pc        = pc_r;
  assign redirect  = redirect_r;
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;

endmodule

// File: tb/tb_ysyx_23060171_pcu.sv
// Scoreboard bench for ysyx_23060171_pcu.
// The driver issues next-PC decisions and queues the expected {redirect, pc}.
// The monitor pops the queue on every fetch handshake and compares.
module tb_ysyx_23060171_pcu;

  logic        clk;
  logic        rst;
  logic [1:0]  PCSrc;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic        redirect;
  logic        misalign;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];

  ysyx_23060171_pcu #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .imm(imm), .rs1(rs1),
    .in_valid(in_valid), .in_ready(in_ready), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .redirect(redirect), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every fetch handshake must match the oldest queued expectation.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_fetch: got pc %h with nothing queued", pc);
        end else begin
          e = exp_q.pop_front();
          check("mon_pc", pc, e[31:0]);
          check("mon_redirect", {31'd0, redirect}, {31'd0, e[32]});
        end
      end
    end
  end

  // Issue one decision from EXEC. Optionally stall the fetch side first.
  // The task returns at EXEC again, one cycle after the fetch handshake.
  task automatic step(input logic [1:0] src, input logic [31:0] im, input logic [31:0] r1,
                      input logic [31:0] exp_pc, input logic exp_rd, input int stall);
    PCSrc = src; imm = im; rs1 = r1; in_valid = 1'b1;
    out_ready = (stall == 0);
    exp_q.push_back({(exp_rd && stall == 0), exp_pc});
    @(posedge clk); #1;
    // in_valid stays high with a different decision; FETCH must ignore it.
    PCSrc = 2'b01; imm = 32'h0000_0100;
    check("step_pc", pc, exp_pc);
    check("step_redirect", {31'd0, redirect}, {31'd0, exp_rd});
    check("step_out_valid", {31'd0, out_valid}, 32'd1);
    check("step_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_pc", pc, exp_pc);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_redirect", {31'd0, redirect}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    check("exec_in_ready", {31'd0, in_ready}, 32'd1);
    check("exec_redirect_drop", {31'd0, redirect}, 32'd0);
  endtask

  // Main directed sequence.
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    PCSrc = 2'b00; imm = 32'd0; rs1 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_out_valid", {31'd0, out_valid}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    rst = 1'b0;
    exp_q.push_back({1'b0, 32'h8000_0000});
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("first_exec_in_ready", {31'd0, in_ready}, 32'd1);
    check("first_exec_out_valid", {31'd0, out_valid}, 32'd0);

    step(2'b00, 32'd0,          32'd0,          32'h8000_0004, 1'b0, 0);
    step(2'b01, 32'h0000_000C,  32'd0,          32'h8000_0010, 1'b1, 0);
    step(2'b01, 32'hFFFF_FFF0,  32'd0,          32'h8000_0000, 1'b1, 0);
    step(2'b10, 32'd0,          32'h8000_1001,  32'h8000_1000, 1'b1, 0);
    step(2'b11, 32'h0000_1234,  32'd0,          32'h8000_1004, 1'b0, 2);
    step(2'b10, 32'h0000_0001,  32'h8000_0003,  32'h8000_0004, 1'b1, 0);
    step(2'b10, 32'd0,          32'hFFFF_FFFC,  32'hFFFF_FFFC, 1'b1, 0);
    step(2'b00, 32'd0,          32'd0,          32'h0000_0000, 1'b0, 0);

    // EXEC without in_valid holds state and pc.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_in_ready", {31'd0, in_ready}, 32'd1);
      check("idle_pc", pc, 32'h0000_0000);
    end
    step(2'b01, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b1, 1);

`ifdef YSYX_23060171_PCU_MISALIGN_EN
    PCSrc = 2'b01; imm = 32'h0000_0002; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("halt_pc", pc, 32'h8000_0000);
      check("halt_misalign", {31'd0, misalign}, 32'd1);
      check("halt_redirect", {31'd0, redirect}, 32'd0);
      check("halt_in_ready", {31'd0, in_ready}, 32'd0);
      check("halt_out_valid", {31'd0, out_valid}, 32'd0);
    end
`else
    step(2'b01, 32'h0000_0002, 32'd0, 32'h8000_0002, 1'b1, 0);
    check("no_misalign", {31'd0, misalign}, 32'd0);
`endif

    // Reset while a decision is offered: the decision is discarded.
    out_ready = 1'b0; in_valid = 1'b1; PCSrc = 2'b01; imm = 32'h0000_0040;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst2_pc", pc, 32'h8000_0000);
    check("rst2_out_valid", {31'd0, out_valid}, 32'd1);
    check("rst2_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst2_redirect", {31'd0, redirect}, 32'd0);
    check("rst2_misalign", {31'd0, misalign}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    exp_q.push_back({1'b0, 32'h8000_0000});
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst2_exec_in_ready", {31'd0, in_ready}, 32'd1);
    step(2'b00, 32'd0, 32'd0, 32'h8000_0004, 1'b0, 0);

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
